// File: rtl/mips_fetch_pkg.sv
// ============================================================================
// Package : mips_fetch_pkg
// Shared entry type and constants for the instruction fetch queue.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package mips_fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] PC_INC              = 32'd4;
    localparam int          FETCH_DEPTH_DEFAULT = 4;

endpackage

`default_nettype wire

// File: rtl/fetch_queue_mem.sv
// ============================================================================
// Module : fetch_queue_mem
// DEPTH-entry fetch entry storage: one synchronous write, one async read.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fetch_queue_mem
    import mips_fetch_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH_DEFAULT,
    parameter int PTR_W = 2
) (
    input  logic               Clk,
    input  logic               we,
    input  logic [PTR_W-1:0]   wr_ptr,
    input  fetch_entry_t       wr_data,
    input  logic [PTR_W-1:0]   rd_ptr,
    output fetch_entry_t       rd_data
);

    fetch_entry_t mem [DEPTH];

    always_ff @(posedge Clk) begin
        if (we) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// Module : fetch_queue
// In-order (PC, instruction) queue between fetch and decode with flush.
// Optional perf counters when FETCH_PERF_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fetch_queue
    import mips_fetch_pkg::*;
#(
    parameter int DEPTH  = FETCH_DEPTH_DEFAULT,
    parameter int PTR_W  = 2,
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] InPC,
    input  logic [DATA_W-1:0] InInstr,
    input  logic              InValid,
    output logic              PCWrite,
    input  logic              Flush,
    output logic [DATA_W-1:0] OutPC,
    output logic [DATA_W-1:0] OutPCPlus4,
    output logic [DATA_W-1:0] OutInstr,
    output logic              OutMisaligned,
    output logic              OutValid,
    input  logic              OutReady
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       StallCycles,
    output logic [15:0]       FlushCount
`endif
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             enq;
    logic             deq;
    fetch_entry_t     wr_entry;
    fetch_entry_t     head;

    // PCWrite depends on registered count only, so no OutReady -> PC path.
    assign PCWrite  = (count != FULL_COUNT);
    assign OutValid = (count != '0);
    assign enq      = InValid && PCWrite && !Flush;
    assign deq      = OutValid && OutReady;

    assign wr_entry.pc    = InPC;
    assign wr_entry.instr = InInstr;

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .Clk     (Clk),
        .we      (enq && !Reset),
        .wr_ptr  (wr_ptr),
        .wr_data (wr_entry),
        .rd_ptr  (rd_ptr),
        .rd_data (head)
    );

    always_ff @(posedge Clk) begin
        if (Reset || Flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is never cleared, so every head-derived output is gated by OutValid.
    assign OutPC         = OutValid ? head.pc : '0;
    assign OutInstr      = OutValid ? head.instr : '0;
    assign OutPCPlus4    = OutValid ? (head.pc + PC_INC) : '0;
    assign OutMisaligned = OutValid && (head.pc[1:0] != 2'b00);

`ifdef FETCH_PERF_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            StallCycles <= '0;
            FlushCount  <= '0;
        end else begin
            if (InValid && !PCWrite && (StallCycles != '1)) begin
                StallCycles <= StallCycles + 1'b1;
            end
            if (Flush && (FlushCount != '1)) begin
                FlushCount <= FlushCount + 1'b1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// ============================================================================
// Module : tb_fetch_queue
// Self-checking bench for fetch_queue against a queue-based reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_queue;
    import mips_fetch_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        in_valid;
    logic        pc_write;
    logic        flush;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic [31:0] out_instr;
    logic        out_misaligned;
    logic        out_valid;
    logic        out_ready;
`ifdef FETCH_PERF_EN
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
`endif

    always #5 clk = ~clk;

    fetch_queue #(
        .DEPTH  (DEPTH),
        .PTR_W  (2),
        .DATA_W (32)
    ) dut (
        .Clk           (clk),
        .Reset         (reset),
        .InPC          (in_pc),
        .InInstr       (in_instr),
        .InValid       (in_valid),
        .PCWrite       (pc_write),
        .Flush         (flush),
        .OutPC         (out_pc),
        .OutPCPlus4    (out_pc_plus4),
        .OutInstr      (out_instr),
        .OutMisaligned (out_misaligned),
        .OutValid      (out_valid),
        .OutReady      (out_ready)
`ifdef FETCH_PERF_EN
        ,
        .StallCycles   (stall_cycles),
        .FlushCount    (flush_count)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an ordered list of entries plus perf counters.
    fetch_entry_t model_q[$];
    logic [31:0]  m_stall = '0;
    logic [15:0]  m_flush = '0;
    bit           model_live = 0;
    bit           m_full;
    fetch_entry_t new_e;

    always @(posedge clk) begin
        m_full = (model_q.size() == DEPTH);
        if (reset) begin
            model_q.delete();
            m_stall = '0;
            m_flush = '0;
        end else begin
            if (in_valid && m_full && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
            if (flush) begin
                if (m_flush != 16'hFFFF) m_flush = m_flush + 1;
                model_q.delete();
            end else begin
                if (model_q.size() != 0 && out_ready) void'(model_q.pop_front());
                if (in_valid && !m_full) begin
                    new_e.pc    = in_pc;
                    new_e.instr = in_instr;
                    model_q.push_back(new_e);
                end
            end
        end
        model_live = 1;
    end

    // Compare process: every cycle after the first edge.
    always @(negedge clk) begin
        if (model_live) begin
            if (model_q.size() != 0) begin
                chk("OutValid", {31'b0, out_valid}, 32'd1);
                chk("OutPC", out_pc, model_q[0].pc);
                chk("OutInstr", out_instr, model_q[0].instr);
                chk("OutPCPlus4", out_pc_plus4, model_q[0].pc + 32'd4);
                chk("OutMisaligned", {31'b0, out_misaligned}, {31'b0, model_q[0].pc[1:0] != 2'b00});
            end else begin
                chk("OutValid", {31'b0, out_valid}, 32'd0);
                chk("OutPC", out_pc, 32'd0);
                chk("OutInstr", out_instr, 32'd0);
                chk("OutPCPlus4", out_pc_plus4, 32'd0);
                chk("OutMisaligned", {31'b0, out_misaligned}, 32'd0);
            end
            chk("PCWrite", {31'b0, pc_write}, {31'b0, model_q.size() != DEPTH});
`ifdef FETCH_PERF_EN
            chk("StallCycles", stall_cycles, m_stall);
            chk("FlushCount", {16'b0, flush_count}, {16'b0, m_flush});
`endif
        end
    end

    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                        input logic rdy, input logic fl, input logic rst);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = rdy;
        flush     = fl;
        reset     = rst;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_instr = '0;
        out_ready = 1'b0; flush = 1'b0;

        // 1. reset
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        chk("rst_OutValid", {31'b0, out_valid}, 32'd0);
        chk("rst_PCWrite", {31'b0, pc_write}, 32'd1);
        chk("rst_OutPC", out_pc, 32'd0);
`ifdef FETCH_PERF_EN
        chk("rst_StallCycles", stall_cycles, 32'd0);
        chk("rst_FlushCount", {16'b0, flush_count}, 32'd0);
`endif

        // 2. fill with decode stalled, then drain
        for (int i = 0; i < 4; i++) step(1, 32'(4*i), 32'h2008_0001 + 32'(i), 0, 0, 0);
        chk("full_PCWrite", {31'b0, pc_write}, 32'd0);
        step(1, 32'd16, 32'h2008_0005, 0, 0, 0);
        chk("full_head_PC", out_pc, 32'd0);
        chk("full_head_instr", out_instr, 32'h2008_0001);
        for (int i = 0; i < 4; i++) begin
            chk("drain_PC", out_pc, 32'(4*i));
            chk("drain_PCPlus4", out_pc_plus4, 32'(4*i + 4));
            step(0, 0, 0, 1, 0, 0);
        end
        chk("drained_OutValid", {31'b0, out_valid}, 32'd0);

        // 3. steady stream
        for (int i = 0; i < 8; i++) begin
            step(1, 32'(4*i), 32'h1000_0000 + 32'(i), 1, 0, 0);
            chk("stream_PC", out_pc, 32'(4*i));
            chk("stream_PCWrite", {31'b0, pc_write}, 32'd1);
        end
        step(0, 0, 0, 1, 0, 0);
        chk("stream_empty", {31'b0, out_valid}, 32'd0);

        // 4. flush with handshake and an incoming word
        for (int i = 0; i < 3; i++) step(1, 32'h100 + 32'(4*i), 32'hA0 + 32'(i), 0, 0, 0);
        in_valid = 1; in_pc = 32'h40; in_instr = 32'hDEAD; out_ready = 1; flush = 1;
        #1;
        chk("flush_head_valid", {31'b0, out_valid}, 32'd1);
        chk("flush_head_PC", out_pc, 32'h100);
        @(posedge clk); #1;
        step(0, 0, 0, 1, 0, 0);
        chk("flush_OutValid", {31'b0, out_valid}, 32'd0);
`ifdef FETCH_PERF_EN
        chk("flush_FlushCount", {16'b0, flush_count}, 32'd1);
`endif

        // 5. PC+4 wrap and misaligned PC
        step(1, 32'hFFFF_FFFC, 32'h1, 0, 0, 0);
        chk("wrap_PCPlus4", out_pc_plus4, 32'd0);
        step(0, 0, 0, 1, 0, 0);
        step(1, 32'h0000_0006, 32'h2, 0, 0, 0);
        chk("misaligned_flag", {31'b0, out_misaligned}, 32'd1);
        chk("misaligned_PC", out_pc, 32'h6);
        step(0, 0, 0, 1, 0, 0);

        // 6. full queue, reset and flush together
        for (int i = 0; i < 5; i++) step(1, 32'h200 + 32'(4*i), 32'(i), 0, 0, 0);
        step(1, 32'h300, 0, 1, 1, 1);
        step(0, 0, 0, 0, 0, 0);
        chk("rstfl_OutValid", {31'b0, out_valid}, 32'd0);
        chk("rstfl_PCWrite", {31'b0, pc_write}, 32'd1);
`ifdef FETCH_PERF_EN
        chk("rstfl_StallCycles", stall_cycles, 32'd0);
        chk("rstfl_FlushCount", {16'b0, flush_count}, 32'd0);
`endif
        step(0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
